// File: rtl/count_game_pkg.sv
// Shared types, widths and score arithmetic for the counting-game sequencer.
package count_game_pkg;

  // Game sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RING = 2'd2,
    DONE = 2'd3
  } game_state_e;

  localparam int SCORE_MAX = 99;
  localparam int SCORE_W   = 7;
  localparam int TIME_W    = 4;

  // Score after one accepted hit: one more, but never beyond SCORE_MAX.
  function automatic logic [SCORE_W-1:0] score_add_hit(input logic [SCORE_W-1:0] cur);
    logic [SCORE_W-1:0] nxt;
    if (cur >= SCORE_W'(SCORE_MAX)) begin
      nxt = SCORE_W'(SCORE_MAX);
    end else begin
      nxt = cur + SCORE_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/count_game_ctrl_if.sv
// Start/over handshake between the game sequencer and the beeper.
interface count_game_ctrl_if;
  logic beep_st;    // 0 holds the beeper in reset, 1 lets it run
  logic beep_over;  // beeper reports its melody has finished

  modport master (output beep_st, input beep_over);
  modport slave  (input beep_st, output beep_over);
endinterface

// File: rtl/key_debounce.sv
// Raw active-low key -> synchronised, debounced level -> one-cycle press strobe.
// The accepted level only moves after the synchronised level has disagreed
// with it for DEB_MS consecutive cycles, so a held key gives one strobe.
module key_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Two-flop synchroniser for the asynchronous key; idles at released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Stability counter: restart on agreement, flip the level once stable long enough.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = CNT_W'(0);
    end else if (cnt_q == CNT_W'(DEB_MS - 1)) begin
      cnt_d   = CNT_W'(0);
      level_d = sync2_q;
      press_d = (level_q == 1'b1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state and registered press strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CNT_W'(0);
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/count_game_ctrl.sv
// Counting-game sequencer: debounced start/hit keys, a GAME_SEC countdown
// driven by a CLK_HZ tick, hit scoring with saturation, then a beeper run
// through the st/over handshake before the game is reported done.
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int GAME_SEC = 10,
  parameter int DEB_MS   = 20,
  parameter int TARGET   = 30
) (
  input  logic                clk,
  input  logic                st,
  input  logic                key_start,
  input  logic                key_hit,
  count_game_ctrl_if.master   beep_if,
  output logic [SCORE_W-1:0]  score,
  output logic [TIME_W-1:0]   time_left,
  output logic                busy,
  output logic                win
);

  localparam int              TICK_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);

  logic start_press;
  logic hit_press;

  game_state_e        state_q;
  game_state_e        state_d;
  logic [TICK_W-1:0]  tick_q;
  logic [TICK_W-1:0]  tick_d;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [TIME_W-1:0]  time_q;
  logic [TIME_W-1:0]  time_d;
  logic               win_q;
  logic               win_d;
  logic               busy_q;
  logic               busy_d;
  logic               beep_st_q;
  logic               beep_st_d;
  logic               tick_fire;

  key_debounce #(.DEB_MS(DEB_MS)) u_deb_start (
    .clk     (clk),
    .rst_n   (st),
    .key_n_i (key_start),
    .press_o (start_press)
  );

  key_debounce #(.DEB_MS(DEB_MS)) u_deb_hit (
    .clk     (clk),
    .rst_n   (st),
    .key_n_i (key_hit),
    .press_o (hit_press)
  );

  // Next-state logic: game flow, second tick, countdown, scoring and win latch.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    score_d   = score_q;
    time_d    = time_q;
    win_d     = win_q;
    tick_fire = (tick_q == TICK_LAST);
    case (state_q)
      IDLE, DONE: begin
        // A start press begins a fresh game from either resting state.
        if (start_press) begin
          state_d = RUN;
          score_d = SCORE_W'(0);
          time_d  = TIME_W'(GAME_SEC);
          tick_d  = TICK_W'(0);
          win_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        // A hit on the final tick still counts before the win is judged.
        if (hit_press) begin
          score_d = score_add_hit(score_q);
        end else begin
          score_d = score_q;
        end
        if (tick_fire) begin
          tick_d = TICK_W'(0);
          if (time_q <= TIME_W'(1)) begin
            state_d = RING;
            time_d  = TIME_W'(0);
            win_d   = (score_d >= SCORE_W'(TARGET));
          end else begin
            time_d = time_q - TIME_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      RING: begin
        if (beep_if.beep_over) begin
          state_d = DONE;
        end else begin
          state_d = RING;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d == RUN) || (state_d == RING);
    // Beeper released one cycle after RING entry and dropped as RING is left.
    beep_st_d = (state_d == RING) && (state_q == RING);
  end

  // State and output registers; st low aborts everything immediately.
  always_ff @(posedge clk or negedge st) begin
    if (!st) begin
      state_q   <= IDLE;
      tick_q    <= TICK_W'(0);
      score_q   <= SCORE_W'(0);
      time_q    <= TIME_W'(GAME_SEC);
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
      beep_st_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      score_q   <= score_d;
      time_q    <= time_d;
      win_q     <= win_d;
      busy_q    <= busy_d;
      beep_st_q <= beep_st_d;
    end
  end

  assign beep_if.beep_st = beep_st_q;
  assign score           = score_q;
  assign time_left       = time_q;
  assign busy            = busy_q;
  assign win             = win_q;

endmodule

// File: tb/tb_count_game_ctrl.sv
// Bench for count_game_ctrl: directed scenarios plus randomised games, all
// expectations taken from the game rules (press latency, seconds left as
// GAME_SEC - elapsed/CLK_HZ, score = min(hits, 99), win = score >= TARGET).
module tb_count_game_ctrl;
  import count_game_pkg::*;

  localparam int CLK_HZ     = 10;
  localparam int GAME_SEC   = 3;
  localparam int DEB_MS     = 4;
  localparam int TARGET     = 2;
  localparam int LAT        = 2 + DEB_MS + 1;   // key edge to game reaction
  localparam int GAME_CYC   = GAME_SEC * CLK_HZ;
  localparam int S_CLK_HZ   = 100;
  localparam int S_GAME_SEC = 15;
  localparam int S_TARGET   = 99;

  logic       clk;
  logic       st;
  logic       key_start;
  logic       key_hit;
  logic [6:0] score;
  logic [3:0] time_left;
  logic       busy;
  logic       win;
  logic       key_start2;
  logic       key_hit2;
  logic [6:0] score2;
  logic [3:0] time_left2;
  logic       busy2;
  logic       win2;

  int          cyc = 0;
  int          checks;
  int          errors;
  int          e_cyc;
  logic [13:0] obs;
  logic [13:0] expv;

  count_game_ctrl_if bus();
  count_game_ctrl_if bus2();

  count_game_ctrl #(.CLK_HZ(CLK_HZ), .GAME_SEC(GAME_SEC), .DEB_MS(DEB_MS), .TARGET(TARGET)) dut (
    .clk(clk), .st(st), .key_start(key_start), .key_hit(key_hit), .beep_if(bus),
    .score(score), .time_left(time_left), .busy(busy), .win(win)
  );

  // Long-game instance so the 99 saturation can actually be reached.
  count_game_ctrl #(.CLK_HZ(S_CLK_HZ), .GAME_SEC(S_GAME_SEC), .DEB_MS(DEB_MS), .TARGET(S_TARGET)) dut_sat (
    .clk(clk), .st(st), .key_start(key_start2), .key_hit(key_hit2), .beep_if(bus2),
    .score(score2), .time_left(time_left2), .busy(busy2), .win(win2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] snap();
    return {bus.beep_st, busy, win, time_left, score};
  endfunction

  function automatic logic [13:0] pack(input logic b, input logic bz, input logic w, input int t, input int s);
    return {b, bz, w, t[3:0], s[6:0]};
  endfunction

  // Seconds left k cycles after the game started.
  function automatic int exp_time(input int k);
    if (k >= GAME_CYC) return 0;
    return GAME_SEC - k / CLK_HZ;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_press();
    int n0;
    n0 = cyc;
    key_start = 1'b0;
    e_cyc = n0 + LAT;
    wait_until(n0 + 6);
    key_start = 1'b1;
  endtask

  task automatic finish_game(input int e, input int d);
    wait_until(e + GAME_CYC + 1 + d);
    bus.beep_over = 1'b1;
    ncyc(1);
    bus.beep_over = 1'b0;
  endtask

  task automatic test_reset();
    st = 1'b0;
    ncyc(3);
    obs = snap(); expv = pack(1'b0, 1'b0, 1'b0, GAME_SEC, 0); checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_active got %h exp %h", obs, expv); end
    st = 1'b1;
    ncyc(3);
    obs = snap(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_release got %h exp %h", obs, expv); end
  endtask

  task automatic test_bounce();
    int n0, lat, e;
    repeat (3) begin
      key_start = 1'b0; ncyc(2); key_start = 1'b1; ncyc(6);
    end
    obs = snap(); expv = pack(1'b0, 1'b0, 1'b0, GAME_SEC, 0); checks++;
    if (obs !== expv) begin errors++; $display("FAIL bounce_glitch_idle got %h exp %h", obs, expv); end
    n0 = cyc; lat = 0; key_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL bounce_latency got %0d exp %0d", lat, LAT); end
    e = cyc;
    wait_until(e + 1);  key_hit = 1'b0;
    wait_until(n0 + 10); key_start = 1'b1;
    wait_until(e + 13); key_hit = 1'b1;
    wait_until(e + 25);
    obs = snap(); expv = pack(1'b0, 1'b1, 1'b0, exp_time(25), 1); checks++;
    if (obs !== expv) begin errors++; $display("FAIL bounce_hold_one_press got %h exp %h", obs, expv); end
    finish_game(e, 0);
  endtask

  task automatic test_game();
    int e;
    start_press(); e = e_cyc; wait_until(e);
    obs = snap(); expv = pack(1'b0, 1'b1, 1'b0, GAME_SEC, 0); checks++;
    if (obs !== expv) begin errors++; $display("FAIL game_enter_from_done got %h exp %h", obs, expv); end
    for (int i = 0; i < 3; i++) begin
      wait_until(e + 10 * i);     key_hit = 1'b0;
      wait_until(e + 10 * i + 5); key_hit = 1'b1;
      wait_until(e + 10 * i + 9);
      obs = snap(); expv = pack(1'b0, 1'b1, 1'b0, exp_time(10 * i + 9), i + 1); checks++;
      if (obs !== expv) begin errors++; $display("FAIL game_tick_%0d got %h exp %h", i, obs, expv); end
    end
    wait_until(e + GAME_CYC);
    obs = snap(); expv = pack(1'b0, 1'b1, 1'b1, 0, 3); checks++;
    if (obs !== expv) begin errors++; $display("FAIL game_ring_entry got %h exp %h", obs, expv); end
    wait_until(e + GAME_CYC + 1);
    obs = snap(); expv = pack(1'b1, 1'b1, 1'b1, 0, 3); checks++;
    if (obs !== expv) begin errors++; $display("FAIL game_beep_st got %h exp %h", obs, expv); end
  endtask

  task automatic test_handshake();
    int d;
    d = $urandom_range(0, 4);
    ncyc(d);
    obs = snap(); expv = pack(1'b1, 1'b1, 1'b1, 0, 3); checks++;
    if (obs !== expv) begin errors++; $display("FAIL hs_wait_ring got %h exp %h", obs, expv); end
    bus.beep_over = 1'b1; ncyc(1); bus.beep_over = 1'b0;
    obs = snap(); expv = pack(1'b0, 1'b0, 1'b1, 0, 3); checks++;
    if (obs !== expv) begin errors++; $display("FAIL hs_done got %h exp %h", obs, expv); end
    bus.beep_over = 1'b1; ncyc(3); bus.beep_over = 1'b0; ncyc(1);
    obs = snap(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL hs_over_ignored got %h exp %h", obs, expv); end
    start_press(); wait_until(e_cyc);
    obs = snap(); expv = pack(1'b0, 1'b1, 1'b0, GAME_SEC, 0); checks++;
    if (obs !== expv) begin errors++; $display("FAIL hs_restart got %h exp %h", obs, expv); end
  endtask

  task automatic test_edge();
    int e;
    e = e_cyc;
    key_hit = 1'b0; wait_until(e + 5); key_hit = 1'b1;
    wait_until(e + GAME_CYC - LAT); key_hit = 1'b0;
    wait_until(e + GAME_CYC - 2);   key_hit = 1'b1;
    wait_until(e + GAME_CYC - 1);
    obs = snap(); expv = pack(1'b0, 1'b1, 1'b0, 1, 1); checks++;
    if (obs !== expv) begin errors++; $display("FAIL edge_before_tick got %h exp %h", obs, expv); end
    wait_until(e + GAME_CYC);
    obs = snap(); expv = pack(1'b0, 1'b1, 1'b1, 0, 2); checks++;
    if (obs !== expv) begin errors++; $display("FAIL edge_final_tick_hit got %h exp %h", obs, expv); end
    finish_game(e, 0);
  endtask

  task automatic test_random_games();
    int h, k, extra, d, e, exp_s;
    logic exp_w;
    for (int g = 0; g < 6; g++) begin
      h = $urandom_range(0, 3); k = $urandom_range(0, 2); extra = $urandom_range(0, 1);
      start_press(); e = e_cyc;
      fork
        begin
          for (int i = 0; i < h; i++) begin
            wait_until(e + k + 10 * i);     key_hit = 1'b0;
            wait_until(e + k + 10 * i + 5); key_hit = 1'b1;
          end
        end
        begin
          if (extra != 0) begin
            wait_until(e + 8);  key_start = 1'b0;
            wait_until(e + 13); key_start = 1'b1;
          end
        end
      join
      exp_s = (h > SCORE_MAX) ? SCORE_MAX : h;
      exp_w = (exp_s >= TARGET);
      wait_until(e + GAME_CYC);
      obs = snap(); expv = pack(1'b0, 1'b1, exp_w, 0, exp_s); checks++;
      if (obs !== expv) begin errors++; $display("FAIL rand_ring g%0d h%0d got %h exp %h", g, h, obs, expv); end
      d = $urandom_range(0, 3);
      finish_game(e, d);
      obs = snap(); expv = pack(1'b0, 1'b0, exp_w, 0, exp_s); checks++;
      if (obs !== expv) begin errors++; $display("FAIL rand_done g%0d got %h exp %h", g, obs, expv); end
    end
  endtask

  task automatic test_saturate();
    int n0, e, exp_s;
    n0 = cyc; key_start2 = 1'b0; wait_until(n0 + 6); key_start2 = 1'b1;
    e = n0 + LAT;
    for (int i = 0; i < 100; i++) begin
      wait_until(e + 10 * i);     key_hit2 = 1'b0;
      wait_until(e + 10 * i + 5); key_hit2 = 1'b1;
      wait_until(e + 10 * i + 9);
      exp_s = (i + 1 > SCORE_MAX) ? SCORE_MAX : i + 1;
      checks++;
      if (score2 !== exp_s[6:0]) begin errors++; $display("FAIL sat_score hit%0d got %0d exp %0d", i + 1, score2, exp_s); end
    end
    wait_until(e + S_GAME_SEC * S_CLK_HZ);
    checks++;
    if ({busy2, win2, time_left2, score2} !== {1'b1, 1'b1, 4'd0, 7'd99}) begin
      errors++; $display("FAIL sat_ring_win got %b%b %0d %0d exp 11 0 99", busy2, win2, time_left2, score2);
    end
  endtask

  task automatic test_abort();
    int e;
    start_press(); e = e_cyc;
    wait_until(e + GAME_CYC + 3);
    obs = snap(); expv = pack(1'b1, 1'b1, 1'b0, 0, 0); checks++;
    if (obs !== expv) begin errors++; $display("FAIL abort_pre_ring got %h exp %h", obs, expv); end
    #2 st = 1'b0;
    #1;
    obs = snap(); expv = pack(1'b0, 1'b0, 1'b0, GAME_SEC, 0); checks++;
    if (obs !== expv) begin errors++; $display("FAIL abort_async got %h exp %h", obs, expv); end
    checks++;
    if ({bus2.beep_st, busy2, score2} !== {1'b0, 1'b0, 7'd0}) begin
      errors++; $display("FAIL abort_sat_dut got %b%b %0d exp 00 0", bus2.beep_st, busy2, score2);
    end
    ncyc(2); st = 1'b1; ncyc(2);
    obs = snap(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL abort_idle got %h exp %h", obs, expv); end
  endtask

  initial begin
    st = 1'b0; key_start = 1'b1; key_hit = 1'b1; key_start2 = 1'b1; key_hit2 = 1'b1;
    bus.beep_over = 1'b0; bus2.beep_over = 1'b0;
    checks = 0; errors = 0; e_cyc = 0;
    test_reset();
    test_bounce();
    test_game();
    test_handshake();
    test_edge();
    test_random_games();
    test_saturate();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
